// File: rtl/detector_pkg.sv
// Shared definitions for the detector stream buffer: write-side FSM state
// encoding and the bit layout of a stored FIFO word {sop, eop, data}.
package detector_pkg;

   // Write-side framing states
   typedef enum logic [1:0] {
      ST_WAIT_SOP = 2'd0,
      ST_PASS     = 2'd1,
      ST_DROP     = 2'd2
   } wr_state_e;

   // Framing bits sit directly above the pixel field: word = {sop, eop, data}
   localparam int EOP_OFS    = 0;
   localparam int SOP_OFS    = 1;
   localparam int WORD_EXTRA = 2;

endpackage

// File: rtl/detector_sc_fifo.sv
// Single-clock FIFO with a registered read port presented as a first-word
// fall-through output. The presented word stays in the memory until it is
// accepted, so level counts it. Pointers carry one extra bit so that a
// completely full memory is distinguishable from an empty one.
module detector_sc_fifo #(
   parameter int WIDTH  = 16,
   parameter int AWIDTH = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [WIDTH-1:0]  rd_data,
   output logic [AWIDTH:0]   level
);

   localparam int DEPTH = 2 ** AWIDTH;
   localparam logic [AWIDTH:0] LVL_FULL = {1'b1, {AWIDTH{1'b0}}};
   localparam logic [AWIDTH:0] PTR_ONE  = {{AWIDTH{1'b0}}, 1'b1};

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [AWIDTH:0]   level_q, level_d;
   logic              valid_q, valid_d;
   logic [WIDTH-1:0]  data_q;
   logic              push, pop, fetch;

   // Next-state for pointers, occupancy and the output stage
   always_comb begin
      push     = wr_en && (level_q != LVL_FULL);
      pop      = valid_q && rd_ready;
      // reload output register when it is empty or being consumed, and a
      // word written on an earlier edge is waiting behind it
      fetch    = (!valid_q || pop) && (wr_ptr_q != rd_ptr_q);
      wr_ptr_d = push  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = fetch ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      valid_d  = fetch ? 1'b1 : (pop ? 1'b0 : valid_q);
      case ({push, pop})
         2'b10:   level_d = level_q + PTR_ONE;
         2'b01:   level_d = level_q - PTR_ONE;
         default: level_d = level_q;
      endcase
   end

   // Control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         valid_q  <= valid_d;
      end
   end

   // Storage array, no reset
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AWIDTH-1:0]] <= wr_data;
   end

   // Registered read data feeding the output
   always_ff @(posedge clk) begin
      if (rst)        data_q <= '0;
      else if (fetch) data_q <= mem_q[rd_ptr_q[AWIDTH-1:0]];
   end

   assign rd_valid = valid_q;
   assign rd_data  = data_q;
   assign level    = level_q;

endmodule

// File: rtl/detector_stream_buffer.sv
// Frame-aware elastic buffer between a detector driver (no backpressure)
// and an Avalon-ST sink. Only whole frames starting with sop are admitted;
// when the FIFO reaches its last free slot the current frame is cut short
// with a forced eop and the rest of it is discarded.
// Optional build macro DETECTOR_DROP_CNT_EN adds a saturating 16-bit
// drop_count output counting truncated frames.
module detector_stream_buffer
   import detector_pkg::*;
#(
   parameter int DATA_WIDTH  = 14,
   parameter int FIFO_AWIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   din_startofpacket,
   input  logic                   din_endofpacket,
   input  logic                   din_valid,
   input  logic [DATA_WIDTH-1:0]  din_data,
   input  logic                   dout_ready,
   output logic                   dout_startofpacket,
   output logic                   dout_endofpacket,
   output logic                   dout_valid,
   output logic [DATA_WIDTH-1:0]  dout_data,
   output logic [FIFO_AWIDTH:0]   fifo_level,
   output logic                   overflow
`ifdef DETECTOR_DROP_CNT_EN
   ,
   output logic [15:0]            drop_count
`endif
);

   localparam int WORD_W = DATA_WIDTH + WORD_EXTRA;
   localparam logic [FIFO_AWIDTH:0] LVL_FULL = {1'b1, {FIFO_AWIDTH{1'b0}}};
   localparam logic [FIFO_AWIDTH:0] LVL_LAST = {1'b0, {FIFO_AWIDTH{1'b1}}};

   wr_state_e          state_q, state_d;
   logic               accept, full, last_slot, truncate;
   logic               wr_en;
   logic [WORD_W-1:0]  wr_word;
   logic [WORD_W-1:0]  rd_word;
   logic               overflow_q;

   // A word belongs to a frame when it opens one or continues one in PASS;
   // DROP and WAIT_SOP both restart on a sop in the same cycle.
   assign accept    = din_valid && (din_startofpacket || (state_q == ST_PASS));
   assign full      = (fifo_level == LVL_FULL);
   assign last_slot = (fifo_level == LVL_LAST);
   assign truncate  = accept && !full && last_slot && !din_endofpacket;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_WAIT_SOP;
      else     state_q <= state_d;
   end

   // FSM next-state
   always_comb begin
      state_d = state_q;
      if (accept) begin
         if (full || truncate)    state_d = ST_DROP;
         else if (din_endofpacket) state_d = ST_WAIT_SOP;
         else                      state_d = ST_PASS;
      end
   end

   // FSM outputs: FIFO write strobe and the word with eop forced on truncation
   always_comb begin
      wr_en   = accept && !full;
      wr_word = '0;
      wr_word[DATA_WIDTH-1:0]      = din_data;
      wr_word[DATA_WIDTH+SOP_OFS]  = din_startofpacket;
      wr_word[DATA_WIDTH+EOP_OFS]  = din_endofpacket || truncate;
   end

   // One-cycle overflow pulse following a truncation
   always_ff @(posedge clk) begin
      if (rst) overflow_q <= 1'b0;
      else     overflow_q <= truncate;
   end

   assign overflow = overflow_q;

`ifdef DETECTOR_DROP_CNT_EN
   logic [15:0] drop_cnt_q;

   // Saturating count of truncated frames
   always_ff @(posedge clk) begin
      if (rst)                                   drop_cnt_q <= '0;
      else if (truncate && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
   end

   assign drop_count = drop_cnt_q;
`endif

   detector_sc_fifo #(
      .WIDTH  (WORD_W),
      .AWIDTH (FIFO_AWIDTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_word),
      .rd_ready (dout_ready),
      .rd_valid (dout_valid),
      .rd_data  (rd_word),
      .level    (fifo_level)
   );

   assign dout_data          = rd_word[DATA_WIDTH-1:0];
   assign dout_startofpacket = rd_word[DATA_WIDTH+SOP_OFS];
   assign dout_endofpacket   = rd_word[DATA_WIDTH+EOP_OFS];

endmodule

// File: tb/tb_detector_stream_buffer.sv
// Scoreboard bench for detector_stream_buffer: a deep instance for framing,
// latency, stall and reset behaviour under random stimulus, and a 16-deep
// instance for frame truncation.
module tb_detector_stream_buffer;

   localparam int DW = 14;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // deep instance
   logic          din_sop = 0, din_eop = 0, din_valid = 0;
   logic [DW-1:0] din_data = '0;
   logic          dout_ready;
   logic          dout_sop, dout_eop, dout_valid;
   logic [DW-1:0] dout_data;
   logic [10:0]   fifo_level;
   logic          overflow;
   // 16-deep instance
   logic          s_sop = 0, s_eop = 0, s_valid = 0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready = 0;
   logic          s_dout_sop, s_dout_eop, s_dout_valid;
   logic [DW-1:0] s_dout_data;
   logic [4:0]    s_fifo_level;
   logic          s_overflow;
`ifdef DETECTOR_DROP_CNT_EN
   logic [15:0]   drop_count, s_drop_count;
`endif

   detector_stream_buffer #(.DATA_WIDTH(DW), .FIFO_AWIDTH(10)) dut (
      .clk(clk), .rst(rst),
      .din_startofpacket(din_sop), .din_endofpacket(din_eop),
      .din_valid(din_valid), .din_data(din_data),
      .dout_ready(dout_ready),
      .dout_startofpacket(dout_sop), .dout_endofpacket(dout_eop),
      .dout_valid(dout_valid), .dout_data(dout_data),
      .fifo_level(fifo_level), .overflow(overflow)
`ifdef DETECTOR_DROP_CNT_EN
      , .drop_count(drop_count)
`endif
   );

   detector_stream_buffer #(.DATA_WIDTH(DW), .FIFO_AWIDTH(4)) dut_s (
      .clk(clk), .rst(rst),
      .din_startofpacket(s_sop), .din_endofpacket(s_eop),
      .din_valid(s_valid), .din_data(s_data),
      .dout_ready(s_ready),
      .dout_startofpacket(s_dout_sop), .dout_endofpacket(s_dout_eop),
      .dout_valid(s_dout_valid), .dout_data(s_dout_data),
      .fifo_level(s_fifo_level), .overflow(s_overflow)
`ifdef DETECTOR_DROP_CNT_EN
      , .drop_count(s_drop_count)
`endif
   );

   int checks = 0;
   int errors = 0;
   logic [DW+1:0] exp_q[$];     // {sop, eop, data}
   logic [DW+1:0] s_exp_q[$];
   bit in_frame = 0;            // reference model: inside an admitted frame
   int ready_mode = 0;          // 0 always, 1 toggle, 2 random, 3 never
   int ovf_cnt = 0, s_ovf_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Drive one word into the deep instance; the reference model admits a word
   // when it carries sop or belongs to an open frame, and a frame closes on eop.
   task automatic send(input logic sop, input logic eop, input logic [DW-1:0] d);
      din_valid = 1'b1; din_sop = sop; din_eop = eop; din_data = d;
      if (sop || in_frame) begin
         exp_q.push_back({sop, eop, d});
         in_frame = !eop;
      end
      @(posedge clk); #1;
      din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
   endtask

   task automatic s_send(input logic sop, input logic eop, input logic [DW-1:0] d);
      s_valid = 1'b1; s_sop = sop; s_eop = eop; s_data = d;
      @(posedge clk); #1;
      s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   // dout_ready driver for the deep instance
   initial begin
      dout_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = !dout_ready;
            2:       dout_ready = ($urandom_range(0, 3) != 0);
            default: dout_ready = 1'b0;
         endcase
      end
   end

   // Monitor for the deep instance: pops on handshake, checks stall stability
   logic [DW+1:0] held_w;
   bit held = 0;
   always @(negedge clk) begin
      logic [DW+1:0] w;
      w = {dout_sop, dout_eop, dout_data};
      if (overflow) ovf_cnt++;
      if (rst) begin
         held = 0;
      end else begin
         if (held) check("stall_hold", 64'({dout_valid, w}), 64'({1'b1, held_w}));
         if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_word: got %0h expected none", w);
            end else begin
               check("word", 64'(w), 64'(exp_q.pop_front()));
            end
         end
         held   = dout_valid && !dout_ready;
         held_w = w;
      end
   end

   // Monitor for the 16-deep instance
   always @(negedge clk) begin
      logic [DW+1:0] w;
      w = {s_dout_sop, s_dout_eop, s_dout_data};
      if (s_overflow) s_ovf_cnt++;
      if (!rst && s_dout_valid && s_ready) begin
         if (s_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL s_unexpected_word: got %0h expected none", w);
         end else begin
            check("s_word", 64'(w), 64'(s_exp_q.pop_front()));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   initial begin
      int len;
      logic s;
      rst = 1'b1;
      idle(3);
      // reset state
      check("rst_valid",    64'(dout_valid), 64'd0);
      check("rst_level",    64'(fifo_level), 64'd0);
      check("rst_sop_eop",  64'({dout_sop, dout_eop}), 64'd0);
      check("rst_data",     64'(dout_data), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      rst = 1'b0;
      idle(1);

      // truncation: 20-pixel frame into 16 slots with the sink stalled
      for (int i = 0; i < 20; i++) s_send(i == 0, i == 19, DW'(100 + i));
      idle(2);
      check("trunc_level", 64'(s_fifo_level), 64'd16);
      check("trunc_ovf",   64'(s_ovf_cnt), 64'd1);
      check("trunc_head",  64'({s_dout_valid, s_dout_sop, s_dout_eop, s_dout_data}),
            64'({1'b1, 1'b1, 1'b0, DW'(100)}));
      for (int i = 0; i < 16; i++) s_exp_q.push_back({i == 0, i == 15, DW'(100 + i)});
      s_ready = 1'b1;
      idle(25);
      check("trunc_drained", 64'(s_exp_q.size()), 64'd0);
      check("trunc_level0",  64'(s_fifo_level), 64'd0);
      for (int i = 0; i < 8; i++) begin
         s_exp_q.push_back({i == 0, i == 7, DW'(200 + i)});
         s_send(i == 0, i == 7, DW'(200 + i));
      end
      idle(12);
      check("refill_drained", 64'(s_exp_q.size()), 64'd0);
      check("refill_ovf",     64'(s_ovf_cnt), 64'd1);
`ifdef DETECTOR_DROP_CNT_EN
      check("drop_count", 64'(s_drop_count), 64'd1);
`endif

      // words before any sop are discarded
      for (int i = 0; i < 5; i++) send(1'b0, i == 4, DW'(50 + i));
      idle(3);
      check("nosop_level", 64'(fifo_level), 64'd0);
      check("nosop_valid", 64'(dout_valid), 64'd0);

      // 16-pixel frame with latency check
      for (int i = 0; i < 16; i++) begin
         send(i == 0, i == 15, DW'(i));
         if (i == 0) check("lat_first_edge",  64'(dout_valid), 64'd0);
         if (i == 1) check("lat_second_edge", 64'({dout_valid, dout_sop, dout_data}),
                           64'({1'b1, 1'b1, DW'(0)}));
      end
      wait_drain("frame16", 40);
      check("frame16_level", 64'(fifo_level), 64'd0);

      // single-word frame
      send(1'b1, 1'b1, DW'(77));
      wait_drain("single", 20);

      // 64-pixel frame with sink toggling every cycle
      ready_mode = 1;
      for (int i = 0; i < 64; i++) send(i == 0, i == 63, DW'(1000 + i));
      wait_drain("toggle64", 200);

      // random frames, stray words, mid-frame sop, random gaps and backpressure
      ready_mode = 2;
      for (int f = 0; f < 12; f++) begin
         repeat ($urandom_range(0, 3)) send(1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
         len = $urandom_range(1, 24);
         for (int i = 0; i < len; i++) begin
            s = (i == 0) || ($urandom_range(0, 19) == 0);
            send(s, i == len - 1, DW'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
      end
      wait_drain("random", 2000);

      // reset in the middle of a buffered frame
      ready_mode = 3;
      idle(2);
      for (int i = 0; i < 5; i++) send(i == 0, 1'b0, DW'(300 + i));
      idle(2);
      check("midrst_level_before", 64'(fifo_level), 64'd5);
      rst = 1'b1;
      exp_q.delete();
      in_frame = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_valid", 64'(dout_valid), 64'd0);
      check("midrst_level", 64'(fifo_level), 64'd0);
      ready_mode = 0;
      for (int i = 5; i < 10; i++) send(1'b0, i == 9, DW'(300 + i));
      idle(4);
      check("midrst_tail_level", 64'(fifo_level), 64'd0);
      check("midrst_tail_valid", 64'(dout_valid), 64'd0);
      for (int i = 0; i < 4; i++) send(i == 0, i == 3, DW'(400 + i));
      wait_drain("after_rst", 40);

      check("deep_no_overflow", 64'(ovf_cnt), 64'd0);
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/detector_stream_buffer.md
DETECTOR_STREAM_BUFFER -- requirements
Module: detector_stream_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14, pixel width in bits.
REQ-002 SHALL have parameter FIFO_AWIDTH, default 10, FIFO address bits (depth = 2**FIFO_AWIDTH words).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port din_startofpacket  input  1  first pixel of frame from detector driver.
REQ-006 SHALL have port din_endofpacket  input  1  last pixel of frame.
REQ-007 SHALL have port din_valid  input  1  pixel strobe; source has no backpressure.
REQ-008 SHALL have port din_data  input  DATA_WIDTH  pixel value.
REQ-009 SHALL have port dout_ready  input  1  sink ready.
REQ-010 SHALL have ports dout_startofpacket, dout_endofpacket, dout_valid  output  1 each  Avalon-ST framing.
REQ-011 SHALL have port dout_data  output  DATA_WIDTH  buffered pixel.
REQ-012 SHALL have port fifo_level  output  FIFO_AWIDTH+1  words currently stored.
REQ-013 SHALL have port overflow  output  1  one-cycle pulse when a frame is truncated.

Function
REQ-014 SHALL store each word as {sop, eop, data} in a single-clock FIFO of depth 2**FIFO_AWIDTH.
REQ-015 SHALL run write-side FSM states WAIT_SOP, PASS, DROP; reset state WAIT_SOP.
REQ-016 WAIT_SOP: SHALL discard valid words without sop; on valid&sop SHALL write word and go PASS (or stay WAIT_SOP if eop also set).
REQ-017 PASS: SHALL write every valid word; on written eop SHALL go WAIT_SOP.
REQ-018 PASS: valid sop without preceding eop SHALL be written as new frame start (previous frame left unterminated is accepted as-is).
REQ-019 SHALL reserve one slot: in PASS or on sop, a valid non-eop word arriving when fifo_level == depth-1 SHALL be written with eop forced 1, pulse overflow, and enter DROP.
REQ-020 A valid word arriving when fifo_level == depth SHALL never be written (cannot occur except via REQ-019 path being bypassed; treated as drop).
REQ-021 DROP: SHALL discard all words until next valid sop, then behave as WAIT_SOP receiving that sop in the same cycle.
REQ-022 Word written at edge N SHALL be visible with dout_valid=1 after edge N+1 (2-cycle latency, registered read data), when FIFO otherwise empty.
REQ-023 dout_valid SHALL be 1 whenever a word is presented; word SHALL advance only when dout_valid & dout_ready; dout_* SHALL hold stable while valid & !ready.
REQ-024 Simultaneous write and read SHALL keep fifo_level unchanged; pointers SHALL wrap modulo depth.
REQ-025 fifo_level SHALL be exact count including the presented output word.

Reset
REQ-026 On rst: FSM=WAIT_SOP, pointers=0, fifo_level=0, dout_valid=0, dout_startofpacket=0, dout_endofpacket=0, dout_data=0, overflow=0.
REQ-027 rst mid-frame SHALL flush FIFO contents; no partial frame emitted after reset release.

Configuration
REQ-028 With DETECTOR_DROP_CNT_EN defined: SHALL add output drop_count  16 bits, incremented per overflow pulse, saturating at 16'hFFFF, cleared by rst.
REQ-029 Without DETECTOR_DROP_CNT_EN: port drop_count SHALL not exist and no counter logic SHALL be built.

Structure
REQ-030 Shared package detector_pkg SHALL hold the FSM state encoding and the FIFO word-layout field positions (sop/eop bit offsets).
REQ-031 FIFO storage and pointers SHALL be a sub-module detector_sc_fifo; FSM and framing stay in detector_stream_buffer.

Verification
REQ-032 Frame of 16 pixels 0..15, dout_ready=1 -> same 16 pixels out, sop on 0, eop on 15, first dout_valid 2 cycles after first din_valid.
REQ-033 FIFO_AWIDTH=4, dout_ready=0, 20-pixel frame -> 16 words stored, word 15 has eop=1, overflow pulses once, pixels 16..19 dropped, fifo_level=16.
REQ-034 After REQ-033, dout_ready=1 and new 8-pixel frame -> truncated frame drained then full 8-pixel frame intact; drop_count=1 if DETECTOR_DROP_CNT_EN.
REQ-035 Words without sop after reset -> nothing output until first sop; then frame passes.
REQ-036 dout_ready toggled 1/0 every cycle during 64-pixel frame -> output sequence identical, no duplicates, data stable while stalled.
REQ-037 rst asserted for 1 cycle mid-frame with 5 words buffered -> dout_valid=0 and fifo_level=0 next cycle; remainder of that frame discarded until next sop.
